key_tone_arbiter: RTL and testbench
===================================

KEY_TONE_ARBITER -- requirements
Module: key_tone_arbiter

Interface
REQ-001 Parameter NUM_KEYS, default 8, number of key requesters sharing the tone generator.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000, stable cycles required before a key change is accepted (10 ms at 100 MHz).
REQ-003 clk  input  1  system clock, 100 MHz; sole clock domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 keys  input  NUM_KEYS  raw asynchronous key levels, 1 = pressed; bit 0 = C4 ... bit 7 = C5.
REQ-006 enable  input  1  synchronous mute control; 0 forces release sequence.
REQ-007 speaker  output  1  square-wave audio output.
REQ-008 active_key  output  3  index of the key currently driving speaker.
REQ-009 active_valid  output  1  high while a note is playing; active_key is valid only when this is high.

Function
REQ-010 Each key SHALL pass a 2-flop synchronizer, then a debouncer that updates the key's clean state only after the input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-011 A press event SHALL be a 0->1 transition of a clean key state; a release event SHALL be a 1->0 transition.
REQ-012 Arbitration SHALL be last-press-wins; simultaneous press events in one cycle SHALL resolve to the lowest index.
REQ-013 On release of the active key while other clean keys are held, the new request SHALL be the lowest-index held key.
REQ-014 FSM states SHALL be IDLE, LOAD, PLAY, SWITCH, DRAIN.
REQ-015 IDLE: speaker=0, active_valid=0; on any held key with enable=1 -> LOAD.
REQ-016 LOAD (one cycle): latch requested index into active_key, load half-period counter with HALF_PERIOD[active_key]-1, assert active_valid -> PLAY.
REQ-017 PLAY: counter decrements each cycle; at counter==0 speaker toggles and counter reloads from the table.
REQ-018 In PLAY, request of a different key -> SWITCH; no held keys or enable=0 -> DRAIN.
REQ-019 SWITCH: continue counting; at the counter==0 where speaker is 1, speaker goes 0 and state -> LOAD with the newest request; note changes are thereby glitch-free.
REQ-020 DRAIN: continue counting; at the counter==0 where speaker is 1, speaker goes 0, active_valid goes 0 -> IDLE.
REQ-021 In DRAIN, a new press with enable=1 SHALL go to SWITCH; in SWITCH, loss of all keys or enable=0 SHALL go to DRAIN.
REQ-022 If speaker is already 0 on entry to SWITCH or DRAIN, the transition SHALL occur at the next counter==0 at which speaker would go 0 (one full period later at most).
REQ-023 Latency from accepted press in IDLE to first speaker rise SHALL be 2 + HALF_PERIOD cycles.
REQ-024 Half-period counter SHALL be 18 bits; table values (cycles, 100 MHz): 191113, 170262, 151685, 143172, 127551, 113636, 101238, 95557.
REQ-025 Requests for index >= NUM_KEYS SHALL be impossible; unused key bits are tied off internally.

Reset
REQ-026 rst SHALL asynchronously force: FSM=IDLE, speaker=0, active_key=0, active_valid=0, counter=0, synchronizer and clean key states=0, debounce counters=0.
REQ-027 Reset asserted mid-note SHALL silence speaker immediately; after release, held keys are re-debounced before any note plays.

Structure
REQ-028 Package tone_pkg SHALL hold the FSM state enum, HALF_PERIOD table, counter width, and key index type.
REQ-029 One sub-module key_debounce (synchronizer + debouncer for one key) SHALL be instantiated NUM_KEYS times.

Verification (DEBOUNCE_CYCLES=4, table overridden to small values, e.g. HALF_PERIOD[k]=10+2k)
REQ-030 Press key 4 from reset -> active_key=4, active_valid=1; speaker rises 2+18 cycles after debounce accepts, then toggles every 18 cycles.
REQ-031 Hold key 2, press key 6 -> speaker completes current high half at 14-cycle spacing, falls, then plays at 22-cycle spacing with active_key=6.
REQ-032 Release key 6 while key 2 and key 5 are held -> switch to active_key=2 at the next falling boundary.
REQ-033 Keys 1 and 3 pressed in the same cycle -> active_key=1.
REQ-034 Key bounce shorter than 4 cycles -> no state change, speaker stays 0.
REQ-035 Assert rst while speaker=1 mid-note -> speaker=0 and active_valid=0 in the same cycle without waiting for a clock; release all keys -> DRAIN ends with speaker=0 and FSM=IDLE.

Source files
------------

// File: rtl/tone_pkg.sv
// Shared types and constants for the key-to-tone arbiter: FSM states,
// half-period table, counter width and key index type.
`default_nettype none

package tone_pkg;

  localparam int MAX_KEYS = 8;
  localparam int CNT_W    = 18;

  typedef logic [2:0]                key_idx_t;
  typedef logic [CNT_W-1:0]          half_t;
  typedef half_t [MAX_KEYS-1:0]      half_tbl_t;

  // Half-period of each note in 100 MHz cycles; element 0 is C4, element 7 is C5.
  localparam half_tbl_t HALF_PERIOD = {
    18'd95557,  18'd101238, 18'd113636, 18'd127551,
    18'd143172, 18'd151685, 18'd170262, 18'd191113
  };

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PLAY   = 3'd2,
    SWITCH = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  function automatic key_idx_t lowest_idx(input logic [MAX_KEYS-1:0] v);
    lowest_idx = '0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = key_idx_t'(i);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_tone_arbiter_if.sv
// Key inputs, mute control and tone outputs of the key-to-tone arbiter.
`default_nettype none

interface key_tone_arbiter_if
  import tone_pkg::*;
#(
  parameter int NUM_KEYS = 8
);

  logic [NUM_KEYS-1:0] keys;
  logic                enable;
  logic                speaker;
  key_idx_t            active_key;
  logic                active_valid;

  modport master (
    output keys, enable,
    input  speaker, active_key, active_valid
  );

  modport slave (
    input  keys, enable,
    output speaker, active_key, active_valid
  );

endinterface

`default_nettype wire

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus debouncer for one key; emits one-cycle press and
// release pulses coincident with the clean-state update.
`default_nettype none

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic clean_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             clean_q;
  logic             press_q;
  logic             release_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      clean_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= key_i;
      sync2_q   <= sync1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      // Any cycle where the input agrees with the clean state restarts the count.
      if (sync2_q != clean_q) begin
        if (cnt_q == CNT_LAST) begin
          clean_q   <= sync2_q;
          press_q   <= sync2_q;
          release_q <= ~sync2_q;
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign clean_o   = clean_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

`default_nettype wire

// File: rtl/key_tone_arbiter.sv
// Last-press-wins arbiter sharing one square-wave tone generator among
// debounced keys; note changes and stops only happen on a falling edge.
`default_nettype none

module key_tone_arbiter
  import tone_pkg::*;
#(
  parameter int        NUM_KEYS        = 8,
  parameter int        DEBOUNCE_CYCLES = 1_000_000,
  parameter half_tbl_t HALF_PERIOD_TBL = HALF_PERIOD
) (
  input  logic               clk,
  input  logic               rst,
  key_tone_arbiter_if.slave  tone_if
);

  logic [MAX_KEYS-1:0] clean_w;
  logic [MAX_KEYS-1:0] press_w;
  logic [MAX_KEYS-1:0] release_w;

  generate
    for (genvar i = 0; i < MAX_KEYS; i++) begin : g_key
      if (i < NUM_KEYS) begin : g_used
        key_debounce #(
          .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_key_debounce (
          .clk       (clk),
          .rst       (rst),
          .key_i     (tone_if.keys[i]),
          .clean_o   (clean_w[i]),
          .press_o   (press_w[i]),
          .release_o (release_w[i])
        );
      end else begin : g_unused
        assign clean_w[i]   = 1'b0;
        assign press_w[i]   = 1'b0;
        assign release_w[i] = 1'b0;
      end
    end
  endgenerate

  key_idx_t req_q;
  key_idx_t req_d;

  // A press always wins over a same-cycle release of the requested key.
  always_comb begin
    req_d = req_q;
    if (|press_w) begin
      req_d = lowest_idx(press_w);
    end else if (release_w[req_q] && (|clean_w)) begin
      req_d = lowest_idx(clean_w);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= '0;
    else     req_q <= req_d;
  end

  state_t   state_q;
  half_t    cnt_q;
  logic     speaker_q;
  key_idx_t active_key_q;
  logic     active_valid_q;

  logic  held_w;
  logic  stop_w;
  logic  new_press_w;
  logic  zero_w;
  logic  fall_w;
  half_t tick_cnt_w;
  logic  tick_spk_w;

  assign held_w      = |clean_w;
  assign stop_w      = !held_w || !tone_if.enable;
  assign new_press_w = (|press_w) && tone_if.enable;
  assign zero_w      = (cnt_q == '0);
  assign fall_w      = zero_w && speaker_q;
  assign tick_cnt_w  = zero_w ? (HALF_PERIOD_TBL[active_key_q] - half_t'(1)) : (cnt_q - half_t'(1));
  assign tick_spk_w  = zero_w ? ~speaker_q : speaker_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      speaker_q      <= 1'b0;
      active_key_q   <= '0;
      active_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          speaker_q      <= 1'b0;
          active_valid_q <= 1'b0;
          cnt_q          <= '0;
          if (held_w && tone_if.enable) state_q <= LOAD;
        end
        LOAD: begin
          active_key_q   <= req_q;
          cnt_q          <= HALF_PERIOD_TBL[req_q] - half_t'(1);
          active_valid_q <= 1'b1;
          state_q        <= PLAY;
        end
        PLAY: begin
          cnt_q     <= tick_cnt_w;
          speaker_q <= tick_spk_w;
          if (stop_w)                     state_q <= DRAIN;
          else if (req_q != active_key_q) state_q <= SWITCH;
        end
        SWITCH: begin
          cnt_q     <= tick_cnt_w;
          speaker_q <= tick_spk_w;
          if (fall_w) begin
            if (stop_w) begin
              active_valid_q <= 1'b0;
              state_q        <= IDLE;
            end else begin
              state_q <= LOAD;
            end
          end else if (stop_w) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          cnt_q     <= tick_cnt_w;
          speaker_q <= tick_spk_w;
          if (fall_w) begin
            if (new_press_w) begin
              state_q <= LOAD;
            end else begin
              active_valid_q <= 1'b0;
              state_q        <= IDLE;
            end
          end else if (new_press_w) begin
            state_q <= SWITCH;
          end
        end
        default: begin
          speaker_q      <= 1'b0;
          active_valid_q <= 1'b0;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  assign tone_if.speaker      = speaker_q;
  assign tone_if.active_key   = active_key_q;
  assign tone_if.active_valid = active_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_key_tone_arbiter.sv
// Directed bench for key_tone_arbiter with a 4-cycle debounce and a short
// half-period table (10 + 2*k cycles).
`default_nettype none

module tb_key_tone_arbiter;
  import tone_pkg::*;

  localparam half_tbl_t TB_TBL = {
    18'd24, 18'd22, 18'd20, 18'd18, 18'd16, 18'd14, 18'd12, 18'd10
  };
  localparam int BUDGET = 300;

  logic clk;
  logic rst;

  key_tone_arbiter_if #(.NUM_KEYS(8)) tif ();

  key_tone_arbiter #(
    .NUM_KEYS        (8),
    .DEBOUNCE_CYCLES (4),
    .HALF_PERIOD_TBL (TB_TBL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tone_if (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called on a negedge; counts rising clock edges until speaker reaches level.
  task automatic cycles_until_spk(input logic level, output int n);
    n = 0;
    while (tif.speaker !== level && n < BUDGET) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (tif.active_valid !== 1'b0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 32'(tif.active_valid), 32'd0);
    check_eq({tag, "_spk"}, 32'(tif.speaker), 32'd0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic seen;

    rst        = 1'b1;
    tif.keys   = '0;
    tif.enable = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_spk", 32'(tif.speaker), 32'd0);
    check_eq("rst_valid", 32'(tif.active_valid), 32'd0);
    check_eq("rst_key", 32'(tif.active_key), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single key 4: 6 cycles to accept, then 2 + 18 to first rise.
    tif.keys = 8'b0001_0000;
    cycles_until_spk(1'b1, n);
    check_eq("k4_first_rise", 32'(n), 32'd26);
    check_eq("k4_key", 32'(tif.active_key), 32'd4);
    check_eq("k4_valid", 32'(tif.active_valid), 32'd1);
    cycles_until_spk(1'b0, n);
    check_eq("k4_high_half", 32'(n), 32'd18);
    cycles_until_spk(1'b1, n);
    check_eq("k4_low_half", 32'(n), 32'd18);
    tif.keys = '0;
    wait_idle("k4_stop");

    // Keys 2 and 5 together resolve to 2; then key 6 takes over at a fall.
    tif.keys = 8'b0010_0100;
    cycles_until_spk(1'b1, n);
    check_eq("k25_first_rise", 32'(n), 32'd22);
    check_eq("k25_key", 32'(tif.active_key), 32'd2);
    tif.keys = 8'b0110_0100;
    cycles_until_spk(1'b0, n);
    check_eq("sw6_fall", 32'(n), 32'd14);
    cycles_until_spk(1'b1, n);
    check_eq("sw6_rise", 32'(n), 32'd23);
    check_eq("sw6_key", 32'(tif.active_key), 32'd6);
    cycles_until_spk(1'b0, n);
    check_eq("k6_high_half", 32'(n), 32'd22);

    // Releasing 6 with 2 and 5 held falls back to key 2 on the next fall.
    tif.keys = 8'b0010_0100;
    cycles_until_spk(1'b1, n);
    check_eq("rel6_rise", 32'(n), 32'd22);
    cycles_until_spk(1'b0, n);
    check_eq("rel6_fall", 32'(n), 32'd22);
    check_eq("rel6_key_before", 32'(tif.active_key), 32'd6);
    @(negedge clk);
    check_eq("rel6_key_after", 32'(tif.active_key), 32'd2);
    check_eq("rel6_valid", 32'(tif.active_valid), 32'd1);
    cycles_until_spk(1'b1, n);
    check_eq("k2_rise", 32'(n), 32'd14);
    tif.keys = '0;
    wait_idle("k2_stop");

    // Simultaneous press of 1 and 3 picks key 1.
    tif.keys = 8'b0000_1010;
    cycles_until_spk(1'b1, n);
    check_eq("k13_first_rise", 32'(n), 32'd20);
    check_eq("k13_key", 32'(tif.active_key), 32'd1);

    // Mute mid-high-half: drains at the fall, then restarts when unmuted.
    tif.enable = 1'b0;
    cycles_until_spk(1'b0, n);
    check_eq("mute_fall", 32'(n), 32'd12);
    check_eq("mute_valid", 32'(tif.active_valid), 32'd0);
    tif.enable = 1'b1;
    cycles_until_spk(1'b1, n);
    check_eq("unmute_rise", 32'(n), 32'd14);
    check_eq("unmute_key", 32'(tif.active_key), 32'd1);
    tif.keys = '0;
    wait_idle("k13_stop");

    // A 3-cycle bounce must never be accepted.
    tif.keys = 8'b0000_0001;
    repeat (3) @(negedge clk);
    tif.keys = '0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tif.speaker !== 1'b0 || tif.active_valid !== 1'b0) seen = 1'b1;
    end
    check_eq("bounce_quiet", 32'(seen), 32'd0);

    // Asynchronous reset mid-note, then re-debounce of the still-held key.
    tif.keys = 8'b0001_0000;
    cycles_until_spk(1'b1, n);
    check_eq("pre_rst_rise", 32'(n), 32'd26);
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_spk", 32'(tif.speaker), 32'd0);
    check_eq("async_rst_valid", 32'(tif.active_valid), 32'd0);
    check_eq("async_rst_key", 32'(tif.active_key), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cycles_until_spk(1'b1, n);
    check_eq("post_rst_rise", 32'(n), 32'd26);
    check_eq("post_rst_key", 32'(tif.active_key), 32'd4);
    tif.keys = '0;
    wait_idle("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
